// File: rtl/vc_tdm_domain_arb_pkg.sv
// Shared definitions for the TDM domain arbiter.
//   state_t : arbiter FSM states (IDLE waits for an eligible request, BUSY holds a grant)
//   DOM_L / DOM_H : domain encodings used for cur_dom and the static domain map
package vc_tdm_domain_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic DOM_L = 1'b0;
    localparam logic DOM_H = 1'b1;

endpackage

// File: rtl/vc_EnResetReg.sv
// Register with synchronous active-high reset and load enable.
//   clk, reset : clock and synchronous reset (loads p_reset_value)
//   en, d      : load d when en is high
//   q          : registered value
module vc_EnResetReg #(
    parameter int unsigned             p_nbits       = 1,
    parameter logic [p_nbits-1:0]      p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= p_reset_value;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vc_VariableArbChain.sv
// Variable-priority arbitration chain.
// Picks one requester, searching upward (with wrap) from the one-hot priority position.
//   kin    : kill-in; 1 suppresses every grant
//   prio   : one-hot, marks the highest-priority requester
//   reqs   : request vector
//   grants : one-hot/zero winner
//   kout   : 1 when a winner was produced
module vc_VariableArbChain #(
    parameter int unsigned p_num_reqs = 4
) (
    input  logic                  kin,
    input  logic [p_num_reqs-1:0] prio,
    input  logic [p_num_reqs-1:0] reqs,
    output logic [p_num_reqs-1:0] grants,
    output logic                  kout
);

    logic [2*p_num_reqs-1:0] prio2;
    logic [2*p_num_reqs-1:0] reqs2;
    logic [2*p_num_reqs-1:0] grants2;
    logic                    kill;

    assign prio2 = {{p_num_reqs{1'b0}}, prio};
    assign reqs2 = {reqs, reqs};

    // The request vector is doubled so the search can wrap past the top index.
    // Everything below the priority position starts killed; the priority
    // position re-arms the chain with kin, and the first request after it wins.
    always_comb begin
        grants2 = '0;
        kill    = 1'b1;
        for (int unsigned i = 0; i < 2 * p_num_reqs; i++) begin
            if (prio2[i]) begin
                kill = kin;
            end
            grants2[i] = ~kill & reqs2[i];
            kill       = kill | reqs2[i];
        end
    end

    assign grants = grants2[p_num_reqs-1:0] | grants2[2*p_num_reqs-1:p_num_reqs];
    assign kout   = |grants;

endmodule

// File: rtl/vc_tdm_domain_arb.sv
// Time-division-multiplexed arbiter sharing one resource between two security
// domains. Slots of p_slot_len cycles alternate L/H unconditionally; inside the
// active slot, that domain's requesters are served round-robin.
//   clk, reset : clock, synchronous active-high reset
//   reqs       : level requests, held until granted
//   xact_done  : owner finished its transaction this cycle
//   grants     : registered one-hot/zero grant
//   cur_dom    : domain owning the current slot (0=L, 1=H)
//   slot_cnt   : cycle index within the current slot
//   abort      : 1-cycle pulse when a transaction is cut off at slot end
module vc_tdm_domain_arb
    import vc_tdm_domain_arb_pkg::*;
#(
    parameter int unsigned           p_num_reqs = 4,
    parameter logic [p_num_reqs-1:0] p_dom_mask = 4'b1100,
    parameter int unsigned           p_slot_len = 16,
    parameter int unsigned           p_max_xact = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_num_reqs-1:0]         reqs,
    input  logic                          xact_done,
    output logic [p_num_reqs-1:0]         grants,
    output logic                          cur_dom,
    output logic [$clog2(p_slot_len)-1:0] slot_cnt,
    output logic                          abort
);

    localparam int unsigned           c_cnt_w = $clog2(p_slot_len);
    localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(p_slot_len - 1);
    // Last slot index at which a full-length transaction still fits.
    localparam logic [c_cnt_w-1:0]    c_guard = c_cnt_w'(p_slot_len - p_max_xact - 1);
    localparam logic [p_num_reqs-1:0] c_one   = p_num_reqs'(1);
    // Lowest-index requester of each domain (isolate lowest set bit).
    localparam logic [p_num_reqs-1:0] c_pri_l_rst = ~p_dom_mask & (p_dom_mask + c_one);
    localparam logic [p_num_reqs-1:0] c_pri_h_rst = p_dom_mask & (~p_dom_mask + c_one);

    state_t                  state_q, state_d;
    logic [p_num_reqs-1:0]   grants_d;
    logic                    abort_d;
    logic                    issue;
    logic                    wrap;
    logic                    open_window;
    logic [p_num_reqs-1:0]   eligible;
    logic [p_num_reqs-1:0]   pri_l, pri_h, arb_prio;
    logic [p_num_reqs-1:0]   arb_grants;
    logic [p_num_reqs-1:0]   pri_next;
    logic                    arb_found;

    // Slot timer: free-running, never influenced by traffic.
    assign wrap = (slot_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            cur_dom  <= DOM_L;
        end else if (wrap) begin
            slot_cnt <= '0;
            cur_dom  <= ~cur_dom;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign eligible    = reqs & ((cur_dom == DOM_H) ? p_dom_mask : ~p_dom_mask);
    assign open_window = (slot_cnt <= c_guard);
    assign arb_prio    = (cur_dom == DOM_H) ? pri_h : pri_l;

    vc_VariableArbChain #(
        .p_num_reqs (p_num_reqs)
    ) u_arb (
        .kin    (1'b0),
        .prio   (arb_prio),
        .reqs   (eligible),
        .grants (arb_grants),
        .kout   (arb_found)
    );

    // Winner moves to lowest priority: next priority is the winner rotated left.
    assign pri_next = {arb_grants[p_num_reqs-2:0], arb_grants[p_num_reqs-1]};

    vc_EnResetReg #(
        .p_nbits       (p_num_reqs),
        .p_reset_value (c_pri_l_rst)
    ) u_pri_l (
        .clk   (clk),
        .reset (reset),
        .en    (issue && (cur_dom == DOM_L)),
        .d     (pri_next),
        .q     (pri_l)
    );

    vc_EnResetReg #(
        .p_nbits       (p_num_reqs),
        .p_reset_value (c_pri_h_rst)
    ) u_pri_h (
        .clk   (clk),
        .reset (reset),
        .en    (issue && (cur_dom == DOM_H)),
        .d     (pri_next),
        .q     (pri_h)
    );

    always_comb begin
        state_d  = state_q;
        grants_d = grants;
        abort_d  = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found && open_window) begin
                    issue    = 1'b1;
                    state_d  = BUSY;
                    grants_d = arb_grants;
                end
            end
            BUSY: begin
                // A completion in the wrap cycle takes precedence over abort.
                if (xact_done) begin
                    state_d  = IDLE;
                    grants_d = '0;
                end else if (wrap) begin
                    state_d  = IDLE;
                    grants_d = '0;
                    abort_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                grants_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grants  <= '0;
            abort   <= 1'b0;
        end else begin
            state_q <= state_d;
            grants  <= grants_d;
            abort   <= abort_d;
        end
    end

endmodule

// File: tb/tb_vc_tdm_domain_arb.sv
module tb_vc_tdm_domain_arb;

    localparam int N  = 4;
    localparam int SL = 16;
    localparam int MX = 4;
    localparam logic [3:0] MASK = 4'b1100;

    logic       clk;
    logic       reset;
    logic [3:0] reqs;
    logic       xact_done;
    logic [3:0] grants;
    logic       cur_dom;
    logic [3:0] slot_cnt;
    logic       abort;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: absolute cycle since reset, current owner index.
    logic [3:0] mask_v;
    int         m_cyc;
    int         m_owner;
    int         m_next [2];
    logic       m_abort;
    logic [3:0] m_grants;
    int         m_slot;
    int         m_dom;

    int         q_cyc_a [$];
    int         q_cyc_b [$];
    logic [3:0] q_gnt   [$];

    vc_tdm_domain_arb #(
        .p_num_reqs (N),
        .p_dom_mask (MASK),
        .p_slot_len (SL),
        .p_max_xact (MX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqs      (reqs),
        .xact_done (xact_done),
        .grants    (grants),
        .cur_dom   (cur_dom),
        .slot_cnt  (slot_cnt),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_update_outputs();
        m_grants = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        m_slot   = m_cyc % SL;
        m_dom    = (m_cyc / SL) % 2;
    endtask

    task automatic model_reset();
        m_cyc     = 0;
        m_owner   = -1;
        m_abort   = 1'b0;
        m_next[0] = -1;
        m_next[1] = -1;
        for (int i = 0; i < N; i++) begin
            if (m_next[mask_v[i]] < 0) m_next[mask_v[i]] = i;
        end
        model_update_outputs();
    endtask

    // One clock of the specification: slot = cycle mod SL, domain alternates per slot.
    task automatic model_step(input logic [3:0] r, input logic d);
        int sc;
        int dom;
        int idx;
        sc      = m_cyc % SL;
        dom     = (m_cyc / SL) % 2;
        m_abort = 1'b0;
        if (m_owner >= 0) begin
            if (d) begin
                m_owner = -1;
            end else if (sc == SL - 1) begin
                m_owner = -1;
                m_abort = 1'b1;
            end
        end else if (sc <= SL - MX - 1) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_next[dom] + k) % N;
                if (m_owner < 0 && r[idx] && int'(mask_v[idx]) == dom) begin
                    m_owner     = idx;
                    m_next[dom] = (idx + 1) % N;
                end
            end
        end
        m_cyc++;
        model_update_outputs();
    endtask

    task automatic tick();
        logic [3:0] r;
        logic       d;
        logic       rs;
        r  = reqs;
        d  = xact_done;
        rs = reset;
        @(posedge clk);
        if (rs) model_reset();
        else model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reqs = 4'b0000; xact_done = 1'b0;
        do_reset();
        n_checks++; if (grants !== 4'b0000) begin n_fail++; $display("FAIL reset_grants: got %b want 0000", grants); end
        n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
        n_checks++; if (slot_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", slot_cnt); end
        n_checks++; if (cur_dom !== 1'b0) begin n_fail++; $display("FAIL reset_dom: got %b want 0", cur_dom); end
    endtask

    task automatic test_first_grant();
        reqs = 4'b0011; xact_done = 1'b0;
        do_reset();
        tick();
        n_checks++; if (grants !== 4'b0001) begin n_fail++; $display("FAIL first_grant_c1: got %b want 0001", grants); end
        tick(); tick();
        reqs = 4'b0010;
        xact_done = 1'b1;
        tick();
        xact_done = 1'b0;
        n_checks++; if (grants !== 4'b0000) begin n_fail++; $display("FAIL done_clear_c4: got %b want 0000", grants); end
        tick();
        n_checks++; if (grants !== 4'b0010) begin n_fail++; $display("FAIL second_grant_c5: got %b want 0010", grants); end
        n_checks++; if (grants !== m_grants) begin n_fail++; $display("FAIL model_c5: got %b want %b", grants, m_grants); end
    endtask

    task automatic test_h_slot();
        reqs = 4'b1100; xact_done = 1'b0;
        do_reset();
        while (m_cyc < 16) begin
            tick();
            n_checks++; if (grants !== 4'b0000) begin n_fail++; $display("FAIL h_in_l_slot: cycle %0d got %b want 0000", m_cyc, grants); end
        end
        n_checks++; if (cur_dom !== 1'b1 || slot_cnt !== 4'd0) begin n_fail++; $display("FAIL h_slot_start: dom=%b slot=%0d want dom=1 slot=0", cur_dom, slot_cnt); end
        tick();
        n_checks++; if (grants !== 4'b0100) begin n_fail++; $display("FAIL h_grant_c17: got %b want 0100", grants); end
    endtask

    task automatic test_guard();
        reqs = 4'b0000; xact_done = 1'b0;
        do_reset();
        while (m_cyc < 12) tick();
        reqs = 4'b0001;
        while (m_cyc < 32) begin
            tick();
            n_checks++; if (grants !== 4'b0000) begin n_fail++; $display("FAIL guard_no_grant: cycle %0d got %b want 0000", m_cyc, grants); end
        end
        tick();
        n_checks++; if (grants !== 4'b0001) begin n_fail++; $display("FAIL guard_grant_c33: got %b want 0001", grants); end
    endtask

    task automatic test_abort(input bit with_done);
        reqs = 4'b0000; xact_done = 1'b0;
        do_reset();
        tick();
        reqs = 4'b0001;
        tick();
        reqs = 4'b0000;
        n_checks++; if (grants !== 4'b0001) begin n_fail++; $display("FAIL abort_setup_grant: got %b want 0001", grants); end
        while (m_cyc < 15) begin
            tick();
            n_checks++; if (grants !== 4'b0001 || abort !== 1'b0) begin n_fail++; $display("FAIL abort_busy_hold: cycle %0d grants=%b abort=%b want 0001/0", m_cyc, grants, abort); end
        end
        xact_done = with_done;
        tick();
        xact_done = 1'b0;
        n_checks++; if (grants !== 4'b0000) begin n_fail++; $display("FAIL abort_wrap_grants: got %b want 0000", grants); end
        n_checks++; if (abort !== !with_done) begin n_fail++; $display("FAIL abort_pulse: done=%0d got %b want %b", with_done, abort, !with_done); end
        n_checks++; if (cur_dom !== 1'b1 || slot_cnt !== 4'd0) begin n_fail++; $display("FAIL abort_slot: dom=%b slot=%0d want 1/0", cur_dom, slot_cnt); end
        tick();
        n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL abort_width: got %b want 0", abort); end
    endtask

    task automatic run_rr(input bit with_h);
        int held;
        held = 0;
        reqs = 4'b0011; xact_done = 1'b0;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            tick();
            n_checks++; if (grants !== m_grants || abort !== m_abort) begin n_fail++; $display("FAIL rr_model: cycle %0d grants=%b abort=%b want %b/%b", m_cyc, grants, abort, m_grants, m_abort); end
            held = (grants != 4'b0000) ? held + 1 : 0;
            if (held == 1 && (grants & ~MASK) != 4'b0000) begin
                if (with_h) q_cyc_b.push_back(m_cyc);
                else begin q_cyc_a.push_back(m_cyc); q_gnt.push_back(grants); end
            end
            xact_done = (held >= 2);
            reqs[1:0] = 2'b11;
            reqs[3:2] = with_h ? 2'($urandom_range(0, 3)) : 2'b00;
        end
        reqs = 4'b0000; xact_done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [3];
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0001;
        q_cyc_a.delete(); q_cyc_b.delete(); q_gnt.delete();
        run_rr(1'b0);
        run_rr(1'b1);
        n_checks++; if (q_gnt.size() < 3) begin n_fail++; $display("FAIL rr_count: got %0d grants want >=3", q_gnt.size()); end
        for (int i = 0; i < 3 && i < q_gnt.size(); i++) begin
            n_checks++; if (q_gnt[i] !== exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", i, q_gnt[i], exp_order[i]); end
        end
        n_checks++; if (q_cyc_a.size() != q_cyc_b.size()) begin n_fail++; $display("FAIL rr_isolation_count: with_h=%0d l_only=%0d", q_cyc_b.size(), q_cyc_a.size()); end
        for (int i = 0; i < q_cyc_a.size() && i < q_cyc_b.size(); i++) begin
            n_checks++; if (q_cyc_b[i] != q_cyc_a[i]) begin n_fail++; $display("FAIL rr_isolation[%0d]: with_h cycle %0d want %0d", i, q_cyc_b[i], q_cyc_a[i]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] act;
        reqs = 4'b0000; xact_done = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            act = (m_dom == 1) ? MASK : ~MASK;
            n_checks++; if (grants !== m_grants) begin n_fail++; $display("FAIL rand_grants: cycle %0d got %b want %b", m_cyc, grants, m_grants); end
            n_checks++; if (abort !== m_abort) begin n_fail++; $display("FAIL rand_abort: cycle %0d got %b want %b", m_cyc, abort, m_abort); end
            n_checks++; if (slot_cnt !== 4'(m_slot) || cur_dom !== 1'(m_dom)) begin n_fail++; $display("FAIL rand_timer: cycle %0d slot=%0d dom=%b want %0d/%0d", m_cyc, slot_cnt, cur_dom, m_slot, m_dom); end
            n_checks++; if ($countones(grants) > 1 || (grants & ~act) != 4'b0000) begin n_fail++; $display("FAIL rand_onehot_domain: cycle %0d grants=%b active=%b", m_cyc, grants, act); end
            for (int i = 0; i < N; i++) begin
                if (grants[i]) reqs[i] = 1'b0;
                else if (!reqs[i] && $urandom_range(0, 3) == 0) reqs[i] = 1'b1;
            end
            if (grants != 4'b0000) xact_done = ($urandom_range(0, 3) == 0);
            else xact_done = ($urandom_range(0, 7) == 0);
        end
        reqs = 4'b0000; xact_done = 1'b0;
    endtask

    task automatic test_reset_busy();
        reqs = 4'b0011; xact_done = 1'b0;
        do_reset();
        tick();
        reqs = 4'b0010;
        while (m_cyc < 7) tick();
        n_checks++; if (grants !== 4'b0001) begin n_fail++; $display("FAIL rb_busy_c7: got %b want 0001", grants); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (grants !== 4'b0000 || abort !== 1'b0) begin n_fail++; $display("FAIL rb_cleared: grants=%b abort=%b want 0000/0", grants, abort); end
        n_checks++; if (slot_cnt !== 4'd0 || cur_dom !== 1'b0) begin n_fail++; $display("FAIL rb_timer: slot=%0d dom=%b want 0/0", slot_cnt, cur_dom); end
        reqs = 4'b0011;
        tick();
        n_checks++; if (grants !== 4'b0001) begin n_fail++; $display("FAIL rb_priority_reset: got %b want 0001", grants); end
        reqs = 4'b0000;
    endtask

    initial begin
        mask_v    = MASK;
        reset     = 1'b1;
        reqs      = 4'b0000;
        xact_done = 1'b0;
        model_reset();
        test_reset();
        test_first_grant();
        test_h_slot();
        test_guard();
        test_abort(1'b0);
        test_abort(1'b1);
        test_round_robin();
        test_random();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
